// File: rtl/imm_encode_loader_if.sv
// Stream bundle for imm_encode_loader: instruction/immediate input stream
// and the instruction-memory write port.
interface imm_encode_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [1:0]        in_imm_src;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Host/memory side
  modport master (
    output in_valid, in_instr, in_imm_src, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_instr, in_imm_src, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imm_encode_loader.sv
// Packs 32-bit immediates into RISC-V I/S/B/J fields of base instruction words
// and streams the results into instruction memory at consecutive word addresses.
module imm_encode_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imm_encode_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  jobCount, acceptedCount, errCount;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              slotFull;
  logic              startJob, accept, drain, lastDrain;
  logic [31:0]       encoded;
  logic              legal;

  assign startJob     = (state == IDLE) && start;
  assign drain        = slotFull && bus.mem_ready;
  assign bus.in_ready = (state == LOAD) && (acceptedCount < jobCount) &&
                        (!slotFull || bus.mem_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  // The last write is a drain with every word already accepted.
  assign lastDrain    = (state == LOAD) && drain && (acceptedCount == jobCount);

  // Immediate packing plus legality: the value must sign-extend from the
  // field width, and B/J targets must be even.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    encoded = bus.in_instr;
    legal   = 1'b0;
    unique case (bus.in_imm_src)
      2'd0: begin
        encoded[31:20] = bus.in_imm[11:0];
        legal = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
      end
      2'd1: begin
        encoded[31:25] = bus.in_imm[11:5];
        encoded[11:7]  = bus.in_imm[4:0];
        legal = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
      end
      2'd2: begin
        encoded[31]    = bus.in_imm[12];
        encoded[30:25] = bus.in_imm[10:5];
        encoded[11:8]  = bus.in_imm[4:1];
        encoded[7]     = bus.in_imm[11];
        legal = ((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) && !bus.in_imm[0];
      end
      default: begin
        encoded[31]    = bus.in_imm[20];
        encoded[30:21] = bus.in_imm[10:1];
        encoded[20]    = bus.in_imm[11];
        encoded[19:12] = bus.in_imm[19:12];
        legal = ((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) && !bus.in_imm[0];
      end
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = (word_count != '0) ? LOAD : DONE;
      LOAD:    if (lastDrain) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jobCount      <= '0;
      acceptedCount <= '0;
      errCount      <= '0;
      err           <= 1'b0;
      memAddr       <= '0;
      // NOTE: the slot data is reset as well because mem_wdata has a defined reset value.
      memWdata      <= '0;
      slotFull      <= 1'b0;
    end else if (startJob) begin
      jobCount      <= word_count;
      acceptedCount <= '0;
      errCount      <= '0;
      err           <= 1'b0;
      memAddr       <= base_addr & ~ADDR_W'(3);
    end else begin
      if (drain) memAddr <= memAddr + ADDR_W'(4);
      if (accept) begin
        acceptedCount <= acceptedCount + CNT_W'(1);
        memWdata      <= encoded;
        if (!legal) begin
          err <= 1'b1;
          if (errCount != '1) errCount <= errCount + CNT_W'(1);
        end
      end
      // Accept wins over drain so fill-and-drain in one cycle keeps the slot full.
      if (accept)     slotFull <= 1'b1;
      else if (drain) slotFull <= 1'b0;
    end
  end

  assign bus.mem_we    = slotFull;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err_count     = errCount;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Scoreboard bench for imm_encode_loader: directed vectors plus randomized jobs
// checked against a field-table encoder and a sign-extend decoder.
module tb_imm_encode_loader;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, err;
  logic [CNT_W-1:0]  err_count;

  imm_encode_loader_if #(.ADDR_W(ADDR_W)) bus();

  imm_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        legal;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  exp_t        sbq[$];
  int          writeCyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          jobErrs = 0;
  logic [31:0] nextAddr = '0;
  bit          rndDone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: a per-bit table saying which immediate bit lands where.
  function automatic logic [31:0] modelEncode(input logic [31:0] instr, input logic [1:0] src,
                                              input logic [31:0] imm);
    int map[32];
    logic [31:0] r;
    for (int b = 0; b < 32; b++) map[b] = -1;
    case (src)
      2'd0: for (int i = 0; i < 12; i++) map[20+i] = i;
      2'd1: begin
        for (int i = 5; i < 12; i++) map[20+i] = i;
        for (int i = 0; i < 5; i++)  map[7+i]  = i;
      end
      2'd2: begin
        map[31] = 12;
        map[7]  = 11;
        for (int i = 5; i < 11; i++) map[20+i] = i;
        for (int i = 1; i < 5; i++)  map[7+i]  = i;
      end
      default: begin
        map[31] = 20;
        map[20] = 11;
        for (int i = 1; i < 11; i++)  map[20+i] = i;
        for (int i = 12; i < 20; i++) map[i]    = i;
      end
    endcase
    for (int b = 0; b < 32; b++) r[b] = (map[b] < 0) ? instr[b] : imm[map[b]];
    return r;
  endfunction

  function automatic bit modelLegal(input logic [1:0] src, input logic [31:0] imm);
    longint v = longint'($signed(imm));
    case (src)
      2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
      2'd2:       return (v >= -4096) && (v <= 4094) && !imm[0];
      default:    return (v >= -1048576) && (v <= 1048574) && !imm[0];
    endcase
  endfunction

  // Datapath sign-extend stage, used for the round-trip property.
  function automatic logic [31:0] decodeImm(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      default: return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Monitor: a write handshake is visible at the negedge before the edge that completes it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.mem_we && bus.mem_ready) begin
      writeCyc.push_back(cyc);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
        if (e.legal) check("roundtrip", decodeImm(bus.mem_wdata, e.src), e.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startJob(input logic [31:0] base, input int cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(cnt);
    nextAddr   = base & ~32'd3;
    jobErrs    = 0;
    writeCyc.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic sendRaw(input logic [31:0] instr, input logic [1:0] src, input logic [31:0] imm);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_imm_src = src;
    bus.in_imm     = imm;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1'b1);
    tick();
  endtask

  task automatic pushExp(input logic [31:0] data, input logic [1:0] src, input logic [31:0] imm);
    bit lg = modelLegal(src, imm);
    if (!lg) jobErrs++;
    sbq.push_back('{nextAddr, data, lg, imm, src});
    nextAddr = nextAddr + 32'd4;
  endtask

  task automatic sendDirected(input logic [31:0] instr, input logic [1:0] src,
                              input logic [31:0] imm, input logic [31:0] expData);
    pushExp(expData, src, imm);
    sendRaw(instr, src, imm);
  endtask

  task automatic sendModel(input bit allowIllegal);
    logic [31:0] instr, imm;
    logic [1:0]  src;
    instr = $urandom;
    src   = 2'($urandom_range(0, 3));
    case (src)
      2'd0, 2'd1: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      2'd2:       imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      default:    imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
    endcase
    if (allowIllegal && $urandom_range(0, 4) == 0) imm = $urandom;
    pushExp(modelEncode(instr, src, imm), src, imm);
    sendRaw(instr, src, imm);
  endtask

  task automatic endWords();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    check("done_seen", done, 1'b1);
    if (writeCyc.size() > 0) check("done_latency", cyc, writeCyc[$] + 1);
    check("err", err, jobErrs != 0);
    check("err_count", err_count, jobErrs);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    logic [31:0] holdAddr, holdData;
    int n;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_imm_src = '0;
    bus.in_imm     = '0;
    bus.mem_ready  = 1'b1;

    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick();

    // Single I-type word
    startJob(32'h100, 1);
    check("busy_after_start", busy, 1'b1);
    sendDirected(32'h00000093, 2'd0, 32'hFFFFFFFF, 32'hFFF00093);
    endWords();
    waitDone();

    // S/B/J back-to-back at full throughput
    startJob(32'h0, 3);
    sendDirected(32'h00202023, 2'd1, 32'd8, 32'h00202423);
    sendDirected(32'h00000063, 2'd2, -32'sd4, 32'hFE000EE3);
    sendDirected(32'h000000EF, 2'd3, 32'h800, 32'h001000EF);
    endWords();
    waitDone();
    check("b2b_writes", writeCyc.size(), 3);
    if (writeCyc.size() == 3) begin
      check("b2b_gap1", writeCyc[1], writeCyc[0] + 1);
      check("b2b_gap2", writeCyc[2], writeCyc[1] + 1);
    end

    // Unencodable immediates still get written, and are flagged
    startJob(32'h200, 2);
    sendDirected(32'h00000093, 2'd0, 32'd2048, 32'h80000093);
    sendDirected(32'h00000063, 2'd2, 32'd3, 32'h00000163);
    endWords();
    waitDone();
    check("err_directed", err, 1'b1);
    check("err_count_directed", err_count, 2);
    startJob(32'h300, 1);
    check("err_cleared", err, 1'b0);
    check("err_count_cleared", err_count, 0);
    sendModel(1'b0);
    endWords();
    waitDone();

    // Back-pressure: memory stalls the first write for three cycles
    bus.mem_ready = 1'b0;
    startJob(32'h400, 4);
    fork
      begin
        for (int i = 0; i < 4; i++) sendModel(1'b0);
        endWords();
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.mem_we && n < 50);
        holdAddr = bus.mem_addr;
        holdData = bus.mem_wdata;
        for (int i = 0; i < 3; i++) begin
          check("bp_mem_we", bus.mem_we, 1'b1);
          check("bp_addr_stable", bus.mem_addr, holdAddr);
          check("bp_data_stable", bus.mem_wdata, holdData);
          check("bp_in_ready", bus.in_ready, 1'b0);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
      end
    join
    waitDone();

    // Address wrap; low base bits are ignored
    startJob(32'hFFFFFFFF, 2);
    sendModel(1'b0);
    sendModel(1'b0);
    endWords();
    waitDone();

    // Empty job
    startJob(32'h500, 0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b1);
    waitDone();
    check("zero_no_writes", writeCyc.size(), 0);

    // A second start while busy must be ignored
    startJob(32'h600, 2);
    start      = 1'b1;
    base_addr  = 32'h700;
    word_count = 16'd5;
    tick();
    start = 1'b0;
    sendModel(1'b0);
    sendModel(1'b0);
    endWords();
    waitDone();

    // Randomized jobs with gaps, illegal immediates and random memory stalls
    for (int j = 0; j < 3; j++) begin
      startJob($urandom, 8);
      rndDone = 1'b0;
      fork
        begin
          for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            sendModel(1'b1);
            endWords();
          end
          rndDone = 1'b1;
        end
        begin
          while (!rndDone) begin
            @(posedge clk);
            #1;
            bus.mem_ready = ($urandom_range(0, 3) != 0);
          end
          bus.mem_ready = 1'b1;
        end
      join
      waitDone();
    end

    // Reset with the output slot full discards the pending word
    bus.mem_ready = 1'b0;
    startJob(32'h800, 3);
    sendModel(1'b0);
    endWords();
    @(negedge clk);
    check("slot_full_before_rst", bus.mem_we, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("midrst_mem_we", bus.mem_we, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    check("midrst_mem_wdata", bus.mem_wdata, 0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_err_count", err_count, 0);
    sbq.delete();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check("post_rst_no_write", bus.mem_we, 1'b0);
    check("post_rst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_encode_loader.md
# imm_encode_loader

Instruction-memory loader that inserts immediates into RISC-V instruction words, the inverse of the datapath's immediate sign-extend stage. It takes base instruction words (immediate fields don't-care), a 32-bit immediate and an ImmSrc type over a valid/ready stream. It packs the immediate into the I/S/B/J field layout and writes the result into instruction memory at consecutive word addresses. It sits between the test/boot host and instruction memory. For every legal immediate, sign-extending the written word with the same ImmSrc returns the original immediate.

## Interface
- ADDR_W, 32, byte-address width of mem_addr
- CNT_W, 16, width of word_count and err_count
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a load job (sampled only in IDLE)
- base_addr  in  ADDR_W  byte address of first word (word-aligned, bits[1:0] ignored)
- word_count  in  CNT_W  number of words in the job
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_instr  in  32  base instruction; immediate-field bits are overwritten
- in_imm_src  in  2  0=I, 1=S, 2=B, 3=J
- in_imm  in  32  signed immediate value
- mem_we  out  1  write request (output slot full)
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  sticky: at least one immediate was unencodable in this job
- err_count  out  CNT_W  number of unencodable words in this job, saturating

## Operation
- FSM: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start with word_count != 0. Latch base_addr & ~3 and word_count. Clear err and err_count.
  - start with word_count == 0 goes IDLE -> DONE.
  - LOAD -> DONE on the write handshake of the last word.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - start outside IDLE is ignored.
- Input handshake: accept when in_valid && in_ready.
  - in_ready = (state==LOAD) && (accepted < count) && (!mem_we || mem_ready).
- Output slot: single register.
  - Filled on accept. Drained on mem_we && mem_ready.
  - Fill and drain in the same cycle is allowed, giving full throughput.
- Encoding (bits not listed pass from in_instr):
  - I: [31:20]=imm[11:0]. Legal range -2048..2047.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Legal range -2048..2047.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Legal range -4096..4094, imm[0]=0.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Legal range -1048576..1048574, imm[0]=0.
- Illegal immediate (out of range, or odd for B/J):
  - The word is still written, with truncated fields as above.
  - err is set and err_count is incremented (holds at 2^CNT_W-1).
  - Both are evaluated at accept.
- mem_addr starts at the latched base and advances by 4 after each write handshake, modulo 2^ADDR_W (wraps silently).

## Timing
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, err=0, err_count=0.
- Control latency:
  - start at edge k: busy=1 and in_ready may be 1 from cycle k+1.
- Data latency:
  - Input accepted at edge k: mem_we=1 with that word's data/address from cycle k+1.
- Back-pressure: mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
- Completion:
  - Last write handshake at edge k: done=1 during cycle k+1. busy=0 and IDLE from cycle k+2.
  - err and err_count hold their job value until the next accepted start.
- rst mid-job:
  - Returns to the reset values on the next edge. The pending slot is discarded; no write is issued.

## Test plan
- I-type: job base 0x100, count 1; in_instr 0x00000093, imm 0xFFFFFFFF, src 0 -> one write, addr 0x100, data 0xFFF00093, err=0, done pulse.
- S/B/J back-to-back: three words at base 0x0, in_valid held.
  - Word 1: 0x00202023, imm 8, S.
  - Word 2: 0x00000063, imm -4, B.
  - Word 3: 0x000000EF, imm 0x800, J.
  - Required writes: 0x00202423 @0x0, 0xFE000EE3 @0x4, 0x001000EF @0x8, on consecutive cycles.
- Errors: I imm 2048 on 0x00000093 -> data 0x80000093. Then B imm 3 -> odd, flagged. End state: err=1, err_count=2. Next start clears both.
- Back-pressure: mem_ready low 3 cycles mid-job -> mem_addr/mem_wdata stable, in_ready=0, no word lost or duplicated.
- Wrap and edge cases:
  - ADDR_W=8, base 0xFC, count 2 -> writes at 0xFC then 0x00.
  - word_count=0 -> done one cycle after start, no writes.
  - start while busy -> ignored.
- Reset mid-job: rst asserted with slot full -> next cycle mem_we=0, busy=0, all outputs at reset values.
- Round-trip: random legal imm per ImmSrc -> existing sign-extend model applied to mem_wdata[31:7] equals in_imm.
